// File: rtl/rv_ops_stage.sv
// rv_ops_stage: operand-select stage of a multithreaded RV32 pipeline.
// It picks op1/op2/op3 from the decoded instruction and holds them in a
// 2-entry in-order skid buffer. A per-thread flush kills buffered entries
// and matching inputs.
// Optional feature: define RV_OPS_FWD_EN to add the wb_* ports. With it,
// write-back data is forwarded into Rs1/Rs2 when the instruction is captured.
module rv_ops_stage #(
    parameter int WIDTH   = 32,
    parameter int THREADS = 4,
    localparam int TID_W  = (THREADS > 1) ? $clog2(THREADS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [TID_W-1:0] in_tid,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [4:0]       rs1_idx,
    input  logic [4:0]       rs2_idx,
    input  logic [WIDTH-1:0] Rs1,
    input  logic [WIDTH-1:0] Rs2,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] PC,
    input  logic [WIDTH-1:0] CSR,
`ifdef RV_OPS_FWD_EN
    input  logic             wb_valid,
    input  logic [TID_W-1:0] wb_tid,
    input  logic [4:0]       wb_idx,
    input  logic [WIDTH-1:0] wb_data,
`endif
    input  logic             flush,
    input  logic [TID_W-1:0] flush_tid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TID_W-1:0] out_tid,
    output logic [WIDTH-1:0] out_op1,
    output logic [WIDTH-1:0] out_op2,
    output logic [WIDTH-1:0] out_op3
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [TID_W-1:0] tid;
        logic [WIDTH-1:0] op1;
        logic [WIDTH-1:0] op2;
        logic [WIDTH-1:0] op3;
    } entry_t;

    entry_t     ent_reg [2];
    entry_t     ent_next [2];
    entry_t     new_entry;
    logic [1:0] count_reg;
    logic [1:0] count_next;
    logic [1:0] surv;
    logic       in_ready_reg;
    logic [1:0] keep;
    logic       pop;
    logic       accept;
    logic       store;
    logic [WIDTH-1:0] rs1_val;
    logic [WIDTH-1:0] rs2_val;

`ifdef RV_OPS_FWD_EN
    // Bypass a same-thread write-back landing this cycle; x0 is never forwarded
    always_comb begin
        rs1_val = Rs1;
        rs2_val = Rs2;
        if (wb_valid && (wb_tid == in_tid) && (wb_idx != 5'd0)) begin
            if (wb_idx == rs1_idx) rs1_val = wb_data;
            if (wb_idx == rs2_idx) rs2_val = wb_data;
        end
    end
`else
    // Register indices only matter for forwarding
    logic unused_idx;
    assign unused_idx = ^{rs1_idx, rs2_idx};
    assign rs1_val = Rs1;
    assign rs2_val = Rs2;
`endif

    // Operand selection by major opcode; op3 carries store data / branch rs2
    always_comb begin
        new_entry.tid = in_tid;
        new_entry.op1 = rs1_val;
        new_entry.op2 = rs2_val;
        new_entry.op3 = '0;
        case (opcode)
            OPC_LOAD, OPC_OPIMM: new_entry.op2 = imm;
            OPC_STORE: begin
                new_entry.op2 = imm;
                new_entry.op3 = rs2_val;
            end
            OPC_JAL, OPC_JALR, OPC_AUIPC: begin
                new_entry.op1 = PC;
                new_entry.op2 = imm;
            end
            OPC_LUI: begin
                new_entry.op1 = '0;
                new_entry.op2 = imm;
            end
            OPC_BRANCH: begin
                new_entry.op1 = PC;
                new_entry.op2 = imm;
                new_entry.op3 = rs2_val;
            end
            OPC_MISC: new_entry.op2 = CSR;
            OPC_SYSTEM: begin
                if ((funct3 == 3'd6) || (funct3 == 3'd7)) begin
                    new_entry.op1 = CSR;
                    new_entry.op2 = imm;
                end else begin
                    new_entry.op2 = CSR;
                end
            end
            default: ;
        endcase
    end

    assign out_valid = (count_reg != 2'd0);
    assign in_ready  = in_ready_reg;
    assign pop       = out_valid && out_ready;
    assign accept    = in_valid && in_ready_reg;
    assign store     = accept && !(flush && (in_tid == flush_tid));

    // A slot survives unless it is empty, flushed, or the head being popped
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_keep
            assign keep[gi] = (count_reg > 2'(gi))
                            && !(flush && (ent_reg[gi].tid == flush_tid))
                            && !((gi == 0) && pop);
        end
    endgenerate

    // Compact the surviving entries toward the head, then append the new one
    always_comb begin
        ent_next[0] = ent_reg[0];
        ent_next[1] = ent_reg[1];
        surv        = 2'd0;
        if (keep[0]) begin
            if (keep[1]) surv = 2'd2;
            else         surv = 2'd1;
        end else if (keep[1]) begin
            ent_next[0] = ent_reg[1];
            surv        = 2'd1;
        end
        if (store) begin
            if (surv == 2'd0) ent_next[0] = new_entry;
            else              ent_next[1] = new_entry;
        end
        count_next = surv + {1'b0, store};
    end

    // Buffer state; in_ready is registered from the post-edge occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) ent_reg[i] <= '0;
            count_reg    <= 2'd0;
            in_ready_reg <= 1'b1;
        end else begin
            for (int i = 0; i < 2; i++) ent_reg[i] <= ent_next[i];
            count_reg    <= count_next;
            in_ready_reg <= (count_next != 2'd2);
        end
    end

    assign out_tid = ent_reg[0].tid;
    assign out_op1 = ent_reg[0].op1;
    assign out_op2 = ent_reg[0].op2;
    assign out_op3 = ent_reg[0].op3;

endmodule

// File: tb/tb_rv_ops_stage.sv
// Testbench for rv_ops_stage: directed scenarios plus randomized traffic,
// checked against a queue-based reference model by a negedge monitor.
module tb_rv_ops_stage;
    localparam int WIDTH = 32;
    localparam int THREADS = 4;
    localparam int TID_W = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [TID_W-1:0] in_tid, flush_tid, out_tid;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [4:0]       rs1_idx, rs2_idx;
    logic [WIDTH-1:0] Rs1, Rs2, imm, PC, CSR, out_op1, out_op2, out_op3;
    logic             wb_valid;
    logic [TID_W-1:0] wb_tid;
    logic [4:0]       wb_idx;
    logic [WIDTH-1:0] wb_data;

    rv_ops_stage #(.WIDTH(WIDTH), .THREADS(THREADS)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_tid(in_tid),
        .opcode(opcode), .funct3(funct3), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
        .Rs1(Rs1), .Rs2(Rs2), .imm(imm), .PC(PC), .CSR(CSR),
`ifdef RV_OPS_FWD_EN
        .wb_valid(wb_valid), .wb_tid(wb_tid), .wb_idx(wb_idx), .wb_data(wb_data),
`endif
        .flush(flush), .flush_tid(flush_tid),
        .out_valid(out_valid), .out_ready(out_ready), .out_tid(out_tid),
        .out_op1(out_op1), .out_op2(out_op2), .out_op3(out_op3)
    );

    typedef struct {
        logic [TID_W-1:0] tid;
        logic [WIDTH-1:0] op1;
        logic [WIDTH-1:0] op2;
        logic [WIDTH-1:0] op3;
    } exp_t;

    exp_t model_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected operands straight from the opcode table
    function automatic exp_t ref_ops(input logic [TID_W-1:0] tid, input logic [6:0] opc,
                                     input logic [2:0] f3, input logic [4:0] i1, input logic [4:0] i2,
                                     input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                                     input logic [31:0] pc, input logic [31:0] csr);
        exp_t e;
        logic [31:0] a, b;
        a = r1;
        b = r2;
`ifdef RV_OPS_FWD_EN
        if (wb_valid && wb_tid == tid && wb_idx != 0 && wb_idx == i1) a = wb_data;
        if (wb_valid && wb_tid == tid && wb_idx != 0 && wb_idx == i2) b = wb_data;
`else
        if (i1 == 5'd31 && i2 == 5'd31) a = r1;
`endif
        e.tid = tid;
        e.op3 = (opc == 7'b0100011 || opc == 7'b1100011) ? b : 32'd0;
        if (opc == 7'b0000011 || opc == 7'b0010011 || opc == 7'b0100011) begin
            e.op1 = a; e.op2 = im;
        end else if (opc == 7'b1101111 || opc == 7'b1100111 || opc == 7'b0010111 || opc == 7'b1100011) begin
            e.op1 = pc; e.op2 = im;
        end else if (opc == 7'b0110111) begin
            e.op1 = 32'd0; e.op2 = im;
        end else if (opc == 7'b0001111) begin
            e.op1 = a; e.op2 = csr;
        end else if (opc == 7'b1110011) begin
            if (f3 >= 3'd6) begin e.op1 = csr; e.op2 = im; end
            else begin e.op1 = a; e.op2 = csr; end
        end else begin
            e.op1 = a; e.op2 = b;
        end
        return e;
    endfunction

    // Reference model: occupancy-limited FIFO with per-thread kill
    task automatic model_step();
        bit rdy, head_flushed;
        if (rst) begin
            model_q.delete();
            return;
        end
        rdy = (model_q.size() < 2);
        head_flushed = (model_q.size() > 0) && flush && (model_q[0].tid == flush_tid);
        if (model_q.size() > 0 && out_ready && !head_flushed) void'(model_q.pop_front());
        if (flush) begin
            for (int i = model_q.size() - 1; i >= 0; i--)
                if (model_q[i].tid == flush_tid) model_q.delete(i);
        end
        if (in_valid && rdy && !(flush && in_tid == flush_tid))
            model_q.push_back(ref_ops(in_tid, opcode, funct3, rs1_idx, rs2_idx, Rs1, Rs2, imm, PC, CSR));
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Monitor: compare DUT head against model head every cycle
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            check("mon_out_valid", 32'(out_valid), 32'(model_q.size() > 0));
            check("mon_in_ready", 32'(in_ready), 32'(model_q.size() < 2));
            if (model_q.size() > 0 && out_valid === 1'b1) begin
                check("mon_tid", 32'(out_tid), 32'(model_q[0].tid));
                check("mon_op1", out_op1, model_q[0].op1);
                check("mon_op2", out_op2, model_q[0].op2);
                check("mon_op3", out_op3, model_q[0].op3);
                if (out_ready)
                    $display("pop tid=%0d op1=%h op2=%h op3=%h", out_tid, out_op1, out_op2, out_op3);
            end
        end
    end

    task automatic idle();
        in_valid = 0; flush = 0; flush_tid = 0; wb_valid = 0; wb_tid = 0; wb_idx = 0; wb_data = 0;
    endtask

    task automatic set_instr(input logic [1:0] tid, input logic [6:0] opc, input logic [31:0] r1,
                             input logic [31:0] r2, input logic [31:0] im);
        in_valid = 1; in_tid = tid; opcode = opc; funct3 = 0; rs1_idx = 5'd1; rs2_idx = 5'd2;
        Rs1 = r1; Rs2 = r2; imm = im; PC = 32'h0000_1000; CSR = 32'h0000_0C5A;
    endtask

    task automatic drain();
        @(posedge clk); #1;
        idle(); out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    logic [6:0] ops [12] = '{7'b0000011, 7'b0010011, 7'b0100011, 7'b0110011, 7'b1101111, 7'b1100111,
                             7'b0010111, 7'b0110111, 7'b1100011, 7'b0001111, 7'b1110011, 7'b1011011};

    initial begin
        rst = 1; idle(); out_ready = 0; in_tid = 0; opcode = 0; funct3 = 0;
        rs1_idx = 0; rs2_idx = 0; Rs1 = 0; Rs2 = 0; imm = 0; PC = 0; CSR = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        mon_en = 1;
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_op1", out_op1, 32'd0);

        // OP x1+x2
        @(posedge clk); #1;
        set_instr(2'd0, 7'b0110011, 32'd5, 32'd7, 32'hDEAD); out_ready = 1;
        @(posedge clk); #1 idle();
        @(negedge clk);
        check("op_valid", 32'(out_valid), 32'd1);
        check("op_op1", out_op1, 32'd5);
        check("op_op2", out_op2, 32'd7);
        check("op_op3", out_op3, 32'd0);
        $display("txn OP op1=%h op2=%h", out_op1, out_op2);

        // LUI ignores Rs1
        drain();
        set_instr(2'd1, 7'b0110111, 32'hFFFF_FFFF, 32'd3, 32'h1234_5000);
        @(posedge clk); #1 idle();
        @(negedge clk);
        check("lui_op1", out_op1, 32'd0);
        check("lui_op2", out_op2, 32'h1234_5000);
        $display("txn LUI op1=%h op2=%h", out_op1, out_op2);

        // Three back-to-back attempts against a stalled output
        drain();
        out_ready = 0;
        set_instr(2'd0, 7'b0110011, 32'hA, 32'h1, 32'h0);
        @(posedge clk); #1 Rs1 = 32'hB;
        @(posedge clk); #1 Rs1 = 32'hC;
        @(negedge clk);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_head", out_op1, 32'hA);
        @(posedge clk); #1 idle(); out_ready = 1;
        @(negedge clk); check("drain_1", out_op1, 32'hA);
        @(negedge clk); check("drain_2", out_op1, 32'hB);
        @(negedge clk); check("drain_empty", 32'(out_valid), 32'd0);
        $display("txn backpressure drained");

        // Flush thread 1 behind... ahead of thread 2
        drain();
        out_ready = 0;
        set_instr(2'd1, 7'b0110011, 32'h11, 32'h0, 32'h0);
        @(posedge clk); #1 set_instr(2'd2, 7'b0110011, 32'h22, 32'h0, 32'h0);
        @(posedge clk); #1 idle(); flush = 1; flush_tid = 2'd1;
        @(posedge clk); #1 idle();
        @(negedge clk);
        check("flush_valid", 32'(out_valid), 32'd1);
        check("flush_tid", 32'(out_tid), 32'd2);
        check("flush_op1", out_op1, 32'h22);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        $display("txn flush head tid=%0d", out_tid);

`ifdef RV_OPS_FWD_EN
        drain();
        set_instr(2'd3, 7'b0110011, 32'h0, 32'h9, 32'h0); rs1_idx = 5'd3;
        wb_valid = 1; wb_tid = 2'd3; wb_idx = 5'd3; wb_data = 32'hA5;
        @(posedge clk); #1 idle();
        @(negedge clk); check("fwd_op1", out_op1, 32'hA5);
        @(posedge clk); #1;
        set_instr(2'd3, 7'b0110011, 32'h77, 32'h9, 32'h0); rs1_idx = 5'd0;
        wb_valid = 1; wb_tid = 2'd3; wb_idx = 5'd0; wb_data = 32'hA5;
        @(posedge clk); #1 idle();
        @(negedge clk); check("fwd_x0_op1", out_op1, 32'h77);
        $display("txn forwarding done");
`endif

        // Reset with two entries buffered
        drain();
        out_ready = 0;
        set_instr(2'd0, 7'b0100011, 32'h5, 32'h6, 32'h7);
        @(posedge clk); #1 set_instr(2'd1, 7'b1100011, 32'h8, 32'h9, 32'hA);
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0; idle();
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_tid", 32'(out_tid), 32'd0);
        check("rst_op1", out_op1, 32'd0);
        check("rst_op2", out_op2, 32'd0);
        check("rst_op3", out_op3, 32'd0);
        $display("txn reset with full buffer");

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            rst       = ($urandom_range(255) == 0);
            in_valid  = ($urandom_range(3) != 0);
            in_tid    = 2'($urandom_range(3));
            opcode    = ops[$urandom_range(11)];
            funct3    = 3'($urandom_range(7));
            rs1_idx   = 5'($urandom_range(3));
            rs2_idx   = 5'($urandom_range(3));
            Rs1 = $urandom; Rs2 = $urandom; imm = $urandom; PC = $urandom; CSR = $urandom;
            flush     = ($urandom_range(5) == 0);
            flush_tid = 2'($urandom_range(3));
            out_ready = ($urandom_range(9) < 6);
            wb_valid  = ($urandom_range(1) == 0);
            wb_tid    = 2'($urandom_range(3));
            wb_idx    = 5'($urandom_range(3));
            wb_data   = $urandom;
        end
        @(posedge clk); #1 idle(); rst = 0; out_ready = 1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("final_empty", 32'(out_valid), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
